acc_power: RTL and testbench
============================

# acc_power

Downstream consumer of one subchannel's correlator dumps. Captures `accumulator_i`/`accumulator_q` on `accumulation_complete`, then computes power I²+Q² sequentially on one shared multiplier. Holds the result with a valid/ack handshake for the tracking-loop/acquisition logic. Optionally sums several dumps noncoherently before presenting a result.

## Interface
- `ACC_WIDTH`, 16: width of the signed two's-complement accumulator inputs.
- `NONCOH_LOG2`, 2: log2 of the number of dumps summed per result; used only with the macro enabled.
- `POWER_WIDTH`, 2*ACC_WIDTH+NONCOH_LOG2: output power width.
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous clear; same effect as reset.
- `accumulator_i` in ACC_WIDTH: signed I dump from the subchannel.
- `accumulator_q` in ACC_WIDTH: signed Q dump from the subchannel.
- `accumulation_complete` in 1: single-cycle pulse; the accumulators are final in this cycle.
- `power_ack` in 1: the consumer accepts the current result.
- `power_valid` out 1: result held and valid.
- `power` out POWER_WIDTH: unsigned I²+Q², or the noncoherent sum of these.
- `dump_i` out ACC_WIDTH: I of the most recently captured dump.
- `dump_q` out ACC_WIDTH: Q of the most recently captured dump.
- `busy` out 1: state is not IDLE.
- `overrun` out 1: sticky flag; a dump was dropped.

## Operation
- Reset or `clear` forces the following: state IDLE; `power_valid`=0; `power`=0; `dump_i`/`dump_q`=0; `busy`=0; `overrun`=0; noncoherent count=0; sum=0.
- FSM states: IDLE, MUL_I, MUL_Q, ADD, HOLD.
  - IDLE: if `accumulation_complete`=1, latch I/Q into `dump_i`/`dump_q` and go to MUL_I.
  - MUL_I: product ← `dump_i`*`dump_i` (signed, 2*ACC_WIDTH bits). Go to MUL_Q.
  - MUL_Q: partial ← product; product ← `dump_q`*`dump_q`. Go to ADD.
  - ADD: sq ← partial+product, zero-extended to POWER_WIDTH. Writing `power` and leaving ADD depend on the macro; see Configuration.
  - HOLD: `power_valid`=1 and `power` stays stable. If `power_ack`=1, go to IDLE and clear `power_valid` at that edge.
- Squares are unsigned. The worst case is (-2^(ACC_WIDTH-1))² ×2 = 2^(2*ACC_WIDTH-1), which fits without overflow.
- `accumulation_complete`=1 in any state other than IDLE drops the dump:
  - `dump_i`/`dump_q` are unchanged.
  - `overrun` is set and stays set until reset or `clear`.
- In HOLD, `power_ack` and `accumulation_complete` in the same cycle: leave HOLD, drop the dump, set `overrun`. IDLE is the only capture state.
- `power_ack` outside HOLD is ignored.
- Reset is asynchronous and valid mid-computation; the partial result is discarded. `clear` takes priority over every other input in the same cycle.

## Timing
- Pulse at cycle n: capture at the end of n. MUL_I in n+1, MUL_Q in n+2, ADD in n+3. `power_valid`=1 from n+4 when a result is produced.
- Earliest next capture: the cycle after `power_ack` is sampled. HOLD→IDLE takes one edge, so the minimum dump period is 5 cycles plus ack latency.
- `dump_i`/`dump_q` update at the end of the capture cycle.
- `busy`=1 from n+1 until the return to IDLE.
- All outputs are registered.

## Configuration
- Macro `ACC_POWER_NONCOHERENT_EN`.
- **Defined:**
  - ADD adds sq into a POWER_WIDTH noncoherent sum and increments the count.
  - If count was 2^NONCOH_LOG2-1: `power` ← sum+sq, count ← 0, sum ← 0, go to HOLD.
  - Otherwise go to IDLE without asserting `power_valid`. `busy` drops and the next dump is accepted normally.
  - Overrun rules are unchanged; a dropped dump does not advance the count.
- **Undefined:** ADD sets `power` ← sq and goes to HOLD. The count and sum registers are absent, and NONCOH_LOG2 only affects POWER_WIDTH.

## Test plan
- Macro off, I=3, Q=-4, pulse at cycle 10, ack at 20 → `power_valid` rises at 14 with `power`=25; `dump_i`=3, `dump_q`=-4 from cycle 11; valid low at 21; `overrun`=0.
- Macro off, I=Q=-32768 (ACC_WIDTH=16) → `power`=2^31 exactly, no wrap.
- Second pulse at n+2, then another during HOLD → both dropped, `overrun`=1, `power` still the first result; a pulse after ack is captured normally.
- Macro on, NONCOH_LOG2=2, four dumps (1,0),(0,2),(3,0),(0,-1) each acked as needed → exactly one `power_valid`, `power`=15, four cycles after the fourth pulse.
- Assert `reset` asynchronously during MUL_Q, then `clear` during HOLD → all outputs return to zero immediately, and the next dump produces a correct fresh result.
- Ack held high continuously with pulses every 5 cycles → every dump is processed, `overrun` stays 0.

Source files
------------

// File: rtl/acc_power.sv
// acc_power: captures I/Q correlator dumps and computes I^2+Q^2 on one shared multiplier.
// Define ACC_POWER_NONCOHERENT_EN to sum 2^NONCOH_LOG2 dumps per presented result.
module acc_power #(
    parameter int ACC_WIDTH   = 16,
    parameter int NONCOH_LOG2 = 2,
    parameter int POWER_WIDTH = 2*ACC_WIDTH+NONCOH_LOG2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic signed [ACC_WIDTH-1:0] accumulator_i,
    input  logic signed [ACC_WIDTH-1:0] accumulator_q,
    input  logic                        accumulation_complete,
    input  logic                        power_ack,
    output logic                        power_valid,
    output logic [POWER_WIDTH-1:0]      power,
    output logic signed [ACC_WIDTH-1:0] dump_i,
    output logic signed [ACC_WIDTH-1:0] dump_q,
    output logic                        busy,
    output logic                        overrun
);
    typedef enum logic [2:0] {IDLE, MUL_I, MUL_Q, ADD, HOLD} state_t;
    state_t                        state_q;
    logic signed [ACC_WIDTH-1:0]   dump_i_q, dump_q_q, mul_a;
    logic signed [2*ACC_WIDTH-1:0] product_d;
    logic [2*ACC_WIDTH-1:0]        product_q, partial_q;
    logic [POWER_WIDTH-1:0]        power_q, sq;
    logic                          valid_q, busy_q, overrun_q;
`ifdef ACC_POWER_NONCOHERENT_EN
    logic [NONCOH_LOG2-1:0]        count_q;
    logic [POWER_WIDTH-1:0]        sum_q;
`endif
    // Squares are never negative, so the sum is taken unsigned and zero-extended.
    always_comb begin
        mul_a     = (state_q == MUL_I) ? dump_i_q : dump_q_q;
        product_d = (2*ACC_WIDTH)'(mul_a) * (2*ACC_WIDTH)'(mul_a);
        sq        = POWER_WIDTH'(partial_q) + POWER_WIDTH'(product_q);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dump_i_q  <= '0;
            dump_q_q  <= '0;
            product_q <= '0;
            partial_q <= '0;
            power_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef ACC_POWER_NONCOHERENT_EN
            count_q   <= '0;
            sum_q     <= '0;
`endif
        end else if (clear) begin
            state_q   <= IDLE;
            dump_i_q  <= '0;
            dump_q_q  <= '0;
            product_q <= '0;
            partial_q <= '0;
            power_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef ACC_POWER_NONCOHERENT_EN
            count_q   <= '0;
            sum_q     <= '0;
`endif
        end else begin
            if (accumulation_complete && state_q != IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (accumulation_complete) begin
                    dump_i_q <= accumulator_i;
                    dump_q_q <= accumulator_q;
                    busy_q   <= 1'b1;
                    state_q  <= MUL_I;
                end
                MUL_I: begin
                    product_q <= product_d;
                    state_q   <= MUL_Q;
                end
                MUL_Q: begin
                    partial_q <= product_q;
                    product_q <= product_d;
                    state_q   <= ADD;
                end
                ADD: begin
`ifdef ACC_POWER_NONCOHERENT_EN
                    if (count_q == '1) begin
                        power_q <= sum_q + sq;
                        sum_q   <= '0;
                        count_q <= '0;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        sum_q   <= sum_q + sq;
                        count_q <= count_q + 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`else
                    power_q <= sq;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
`endif
                end
                HOLD: if (power_ack) begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign power_valid = valid_q;
    assign power       = power_q;
    assign dump_i      = dump_i_q;
    assign dump_q      = dump_q_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_acc_power.sv
// tb_acc_power: randomized self-checking bench for acc_power against an arithmetic power model.
module tb_acc_power;
    localparam int W  = 16;
    localparam int NL = 2;
    localparam int PW = 2*W+NL;
    logic clk = 1'b0;
    logic reset, clear, acc_comp, ack;
    logic signed [W-1:0] ai, aq, di, dq;
    logic valid, busy, overrun;
    logic [PW-1:0] power;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    acc_power #(.ACC_WIDTH(W), .NONCOH_LOG2(NL), .POWER_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .accumulator_i(ai), .accumulator_q(aq),
        .accumulation_complete(acc_comp), .power_ack(ack),
        .power_valid(valid), .power(power),
        .dump_i(di), .dump_q(dq), .busy(busy), .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic signed [W-1:0] i, input logic signed [W-1:0] q);
        ai = i;
        aq = q;
        acc_comp = 1'b1;
        tick();
        acc_comp = 1'b0;
    endtask

    function automatic longint pw(input logic signed [W-1:0] i, input logic signed [W-1:0] q);
        return longint'(i) * longint'(i) + longint'(q) * longint'(q);
    endfunction

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; ack = 1'b0; acc_comp = 1'b0; ai = '0; aq = '0;
        #12;
        n_cmp++;
        if ({valid, busy, overrun, power, di, dq} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%0b b=%0b o=%0b p=%0d i=%0d q=%0d want all 0", valid, busy, overrun, power, di, dq);
        end
        reset = 1'b0;
        tick();
    endtask

`ifdef ACC_POWER_NONCOHERENT_EN
    task automatic test_noncoherent();
        logic signed [W-1:0] ti [4] = '{16'sd1, 16'sd0, 16'sd3, 16'sd0};
        logic signed [W-1:0] tq [4] = '{16'sd0, 16'sd2, 16'sd0, -16'sd1};
        int nvalid = 0;
        for (int k = 0; k < 4; k++) begin
            pulse(ti[k], tq[k]);
            for (int c = 0; c < 3; c++) begin
                if (valid) nvalid++;
                tick();
            end
            if (k < 3) begin
                n_cmp++;
                if (valid !== 1'b0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL noncoh_partial%0d: got v=%0b b=%0b want v=0 b=0", k, valid, busy);
                end
            end
        end
        n_cmp++;
        if (valid !== 1'b1 || nvalid != 0 || longint'(power) != 64'd15) begin
            n_bad++;
            $display("FAIL noncoh_result: got v=%0b early=%0d p=%0d want v=1 early=0 p=15", valid, nvalid, power);
        end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_random_noncoh();
        logic signed [W-1:0] ri, rq;
        longint exp_sum;
        for (int g = 0; g < 4; g++) begin
            exp_sum = 0;
            for (int k = 0; k < 4; k++) begin
                ri = W'($urandom); rq = W'($urandom);
                exp_sum += pw(ri, rq);
                pulse(ri, rq);
                tick(); tick(); tick();
            end
            n_cmp++;
            if (valid !== 1'b1 || longint'(power) != exp_sum) begin
                n_bad++;
                $display("FAIL noncoh_rand%0d: got v=%0b p=%0d want v=1 p=%0d", g, valid, power, exp_sum);
            end
            repeat ($urandom_range(0, 2)) tick();
            ack = 1'b1; tick(); ack = 1'b0;
        end
    endtask
`else
    task automatic test_basic();
        pulse(16'sd3, -16'sd4);
        n_cmp++;
        if (di !== 16'sd3 || dq !== -16'sd4 || busy !== 1'b1 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_capture: got i=%0d q=%0d b=%0b v=%0b want 3 -4 1 0", di, dq, busy, valid);
        end
        tick(); tick();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_early_valid: got %0b want 0", valid);
        end
        tick();
        n_cmp++;
        if (valid !== 1'b1 || longint'(power) != 64'd25) begin
            n_bad++;
            $display("FAIL basic_result: got v=%0b p=%0d want v=1 p=25", valid, power);
        end
        ack = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (valid !== 1'b1 || longint'(power) != 64'd25 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_hold: got v=%0b p=%0d b=%0b want 1 25 1", valid, power, busy);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_ack: got v=%0b b=%0b o=%0b want 0 0 0", valid, busy, overrun);
        end
    endtask

    task automatic test_max();
        pulse(-16'sd32768, -16'sd32768);
        tick(); tick(); tick();
        n_cmp++;
        if (valid !== 1'b1 || longint'(power) != 64'd2147483648) begin
            n_bad++;
            $display("FAIL max_power: got v=%0b p=%0d want v=1 p=2147483648", valid, power);
        end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_overrun();
        pulse(16'sd5, 16'sd6);
        tick();
        pulse(16'sd7, 16'sd8);
        n_cmp++;
        if (overrun !== 1'b1 || di !== 16'sd5 || dq !== 16'sd6) begin
            n_bad++;
            $display("FAIL ovr_busy_drop: got o=%0b i=%0d q=%0d want 1 5 6", overrun, di, dq);
        end
        tick();
        pulse(16'sd9, 16'sd9);
        n_cmp++;
        if (valid !== 1'b1 || longint'(power) != 64'd61 || di !== 16'sd5) begin
            n_bad++;
            $display("FAIL ovr_hold_drop: got v=%0b p=%0d i=%0d want 1 61 5", valid, power, di);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        pulse(16'sd2, 16'sd2);
        tick(); tick(); tick();
        n_cmp++;
        if (valid !== 1'b1 || longint'(power) != 64'd8 || di !== 16'sd2 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_recapture: got v=%0b p=%0d i=%0d o=%0b want 1 8 2 1", valid, power, di, overrun);
        end
        ai = 16'sd1; aq = 16'sd1; ack = 1'b1; acc_comp = 1'b1;
        tick();
        ack = 1'b0; acc_comp = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || di !== 16'sd2) begin
            n_bad++;
            $display("FAIL ovr_ack_and_pulse: got v=%0b b=%0b i=%0d want 0 0 2", valid, busy, di);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_clear: got %0b want 0", overrun);
        end
    endtask

    task automatic test_async_reset();
        pulse(16'sd10, 16'sd20);
        tick();
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({valid, busy, overrun, power, di, dq} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%0b b=%0b o=%0b p=%0d i=%0d want all 0", valid, busy, overrun, power, di);
        end
        #1 reset = 1'b0;
        tick();
        pulse(-16'sd7, 16'sd3);
        tick(); tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        n_cmp++;
        if ({valid, busy, overrun, power, di, dq} !== '0) begin
            n_bad++;
            $display("FAIL clear_hold: got v=%0b b=%0b o=%0b p=%0d i=%0d want all 0", valid, busy, overrun, power, di);
        end
        pulse(16'sd11, -16'sd12);
        tick(); tick(); tick();
        n_cmp++;
        if (valid !== 1'b1 || longint'(power) != 64'd265) begin
            n_bad++;
            $display("FAIL fresh_after_clear: got v=%0b p=%0d want v=1 p=265", valid, power);
        end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_random();
        logic signed [W-1:0] ri, rq;
        int lat;
        for (int k = 0; k < 20; k++) begin
            ri = W'($urandom); rq = W'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            pulse(ri, rq);
            lat = 0;
            while (valid !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            n_cmp++;
            if (valid !== 1'b1 || lat != 3 || longint'(power) != pw(ri, rq)) begin
                n_bad++;
                $display("FAIL rand%0d: got v=%0b lat=%0d p=%0d want v=1 lat=3 p=%0d", k, valid, lat, power, pw(ri, rq));
            end
            repeat ($urandom_range(0, 3)) tick();
            ack = 1'b1; tick(); ack = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] ri, rq;
        int nbad_local = 0;
        ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ri = W'($urandom); rq = W'($urandom);
            pulse(ri, rq);
            tick(); tick(); tick();
            n_cmp++;
            if (valid !== 1'b1 || longint'(power) != pw(ri, rq)) begin
                n_bad++;
                nbad_local++;
                $display("FAIL b2b%0d: got v=%0b p=%0d want v=1 p=%0d", k, valid, power, pw(ri, rq));
            end
            tick();
        end
        ack = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_overrun: got o=%0b b=%0b want 0 0", overrun, busy);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef ACC_POWER_NONCOHERENT_EN
        test_noncoherent();
        test_random_noncoh();
`else
        test_basic();
        test_max();
        test_overrun();
        test_async_reset();
        test_random();
        test_back_to_back();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
